// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC periodic time-read sequencer:
// FSM states, RTC register map and bus idle levels.
package rtc_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT,
        S_A_SET,
        S_A_WR,
        S_A_HLD,
        S_GAP,
        S_R_RD,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int N_REGS_DEF = 6;

    localparam logic [7:0] ADDR_SEG  = 8'h21;
    localparam logic [7:0] ADDR_MIN  = 8'h22;
    localparam logic [7:0] ADDR_HORA = 8'h23;
    localparam logic [7:0] ADDR_DIA  = 8'h24;
    localparam logic [7:0] ADDR_MES  = 8'h25;
    localparam logic [7:0] ADDR_ANIO = 8'h26;

    localparam logic STROBE_IDLE = 1'b1;

    // Time registers are contiguous starting at the seconds register.
    function automatic logic [7:0] reg_addr(input logic [2:0] idx);
        return ADDR_SEG + {5'd0, idx};
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Bus phase timer: counts 0..CLK_DIV-1 and flags the last cycle of each phase.
// Held at zero while cleared so every phase starts with a full CLK_DIV cycles.
module rtc_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic phase_end
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [TW-1:0] cnt;

    assign phase_end = (cnt == TW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

endmodule

// File: rtl/rtc_lectura_seq.sv
// Periodic RTC time-read sequencer on the A/D-multiplexed bus; values are gathered
// in shadow registers and published atomically once a whole sweep has completed.
module rtc_lectura_seq
    import rtc_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int POLL_CYCLES = 50000,
    parameter int N_REGS      = N_REGS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       init_done,
    input  logic [7:0] data_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ADn,
    output logic       CSn,
    output logic       WRn,
    output logic       RDn,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic       valid,
    output logic       busy
);

    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES + 1) : 1;

    state_t        state, state_n;
    logic          go, run, phase_end, last_reg;
    logic [PW-1:0] poll;
    logic [2:0]    idx;
    logic [7:0]    shadow [N_REGS];
    logic [7:0]    bank   [N_REGS];

    assign go       = en & init_done;
    assign last_reg = (idx == 3'(N_REGS - 1));
    assign run      = (state == S_A_SET) || (state == S_A_WR) || (state == S_A_HLD) ||
                      (state == S_GAP)   || (state == S_R_RD);

    rtc_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (!run),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        ad_out  = '0;
        ad_oe   = 1'b0;
        ADn     = STROBE_IDLE;
        CSn     = STROBE_IDLE;
        WRn     = STROBE_IDLE;
        RDn     = STROBE_IDLE;
        busy    = 1'b0;
        case (state)
            S_IDLE: if (go) state_n = S_WAIT;
            S_WAIT: begin
                if (!go) state_n = S_IDLE;
                else if (poll == '0) state_n = S_A_SET;
            end
            S_A_SET, S_A_WR, S_A_HLD: begin
                busy   = 1'b1;
                CSn    = 1'b0;
                ADn    = 1'b0;
                ad_oe  = 1'b1;
                ad_out = reg_addr(idx);
                WRn    = (state == S_A_WR) ? 1'b0 : STROBE_IDLE;
                if (phase_end) begin
                    if (state == S_A_SET)     state_n = S_A_WR;
                    else if (state == S_A_WR) state_n = S_A_HLD;
                    else                      state_n = S_GAP;
                end
            end
            // Bus released for a full phase before the RTC may drive it.
            S_GAP: begin
                busy = 1'b1;
                if (phase_end) state_n = S_R_RD;
            end
            S_R_RD: begin
                busy = 1'b1;
                CSn  = 1'b0;
                RDn  = 1'b0;
                if (phase_end) state_n = go ? S_NEXT : S_IDLE;
            end
            S_NEXT: begin
                busy    = 1'b1;
                state_n = last_reg ? S_DONE : S_A_SET;
            end
            S_DONE: begin
                busy    = 1'b1;
                state_n = go ? S_WAIT : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            poll  <= '0;
            idx   <= '0;
            valid <= 1'b0;
            for (int i = 0; i < N_REGS; i++) bank[i] <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: if (go) poll <= PW'(POLL_CYCLES - 1);
                S_WAIT: begin
                    if (!go) poll <= '0;
                    else if (poll != '0) poll <= poll - PW'(1);
                end
                S_R_RD: begin
                    if (phase_end) begin
                        shadow[idx] <= data_in;
                        if (!go) idx <= '0;
                    end
                end
                S_NEXT: if (!last_reg) idx <= idx + 3'd1;
                S_DONE: begin
                    for (int i = 0; i < N_REGS; i++) bank[i] <= shadow[i];
                    valid <= 1'b1;
                    idx   <= '0;
                    if (go) poll <= PW'(POLL_CYCLES - 1);
                end
                default: ;
            endcase
        end
    end

    assign seg  = bank[0];
    assign min  = bank[1];
    assign hora = bank[2];
    assign dia  = bank[3];
    assign mes  = bank[4];
    assign anio = bank[5];

endmodule

// File: tb/tb_rtc_lectura_seq.sv
// Randomised scoreboard bench for rtc_lectura_seq with an RTC bus model and protocol checker.
module tb_rtc_lectura_seq;

    localparam int CLK_DIV = 2;
    localparam int POLL    = 10;
    localparam int NR      = 6;
    localparam int LAT_FIRST  = 1 + POLL + NR * (5 * CLK_DIV + 1) + 1;
    localparam int LAT_PERIOD = POLL + NR * (5 * CLK_DIV + 1) + 1;

    typedef logic [47:0] tuple_t;

    logic       clk = 1'b0;
    logic       reset, en, init_done;
    logic [7:0] data_in, ad_out;
    logic       ad_oe, ADn, CSn, WRn, RDn;
    logic [7:0] seg, min, hora, dia, mes, anio;
    logic       valid, busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mem    [NR];
    logic [7:0] served [NR];
    logic [7:0] latched   = 8'h00;
    logic [7:0] last_read = 8'h00;
    tuple_t     exp_q [$];

    rtc_lectura_seq #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL), .N_REGS(NR)) dut (
        .clk(clk), .reset(reset), .en(en), .init_done(init_done), .data_in(data_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .ADn(ADn), .CSn(CSn), .WRn(WRn), .RDn(RDn),
        .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
        .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // RTC bus model: answers a read with the register selected by the last address write.
    always_comb begin
        data_in = 8'h00;
        if (!CSn && !RDn && latched >= 8'h21 && latched <= 8'h26)
            data_in = mem[int'(latched) - 33];
    end

    int         exp_idx = 0;
    int         wr_low  = 0;
    logic       prev_wr = 1'b1;
    logic       prev_rd = 1'b1;
    logic [7:0] rd_val  = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            exp_idx = 0;
            wr_low  = 0;
            prev_wr = 1'b1;
            prev_rd = 1'b1;
        end else begin
            if (!busy) exp_idx = 0;
            check("oe_with_rd", {63'd0, ad_oe && !RDn}, 64'd0);
            check("wr_qualified", {63'd0, !WRn && (ADn || CSn)}, 64'd0);
            if (!WRn) begin
                wr_low++;
                latched = ad_out;
            end
            if (WRn && !prev_wr) begin
                check("wr_width", 64'(wr_low), 64'(CLK_DIV));
                check("addr_seq", {56'd0, latched}, 64'(8'h21 + exp_idx));
                wr_low = 0;
            end
            if (!RDn) rd_val = data_in;
            if (RDn && !prev_rd) begin
                if (exp_idx < NR) served[exp_idx] = rd_val;
                last_read = latched;
                if (exp_idx == NR - 1)
                    exp_q.push_back({served[5], served[4], served[3], served[2], served[1], served[0]});
                exp_idx++;
            end
            prev_wr = WRn;
            prev_rd = RDn;
        end
    end

    // Scoreboard monitor: outputs must hold between pulses and match a completed sweep on valid.
    tuple_t last_out = '0;
    tuple_t cur;
    always @(negedge clk) begin
        cur = {anio, mes, dia, hora, min, seg};
        if (reset) begin
            last_out = '0;
        end else if (valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: got outputs %0h, required no pulse", cur);
            end else begin
                check("sweep_values", {16'd0, cur}, {16'd0, exp_q.pop_front()});
            end
            last_out = cur;
        end else begin
            check("outputs_hold", {16'd0, cur}, {16'd0, last_out});
        end
    end

    int  cnt, bad;
    bit  ok, chg;

    initial begin
        reset = 1'b1; en = 1'b0; init_done = 1'b0;
        for (int i = 0; i < NR; i++) mem[i] = 8'h10 + 8'(i);
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobes", {60'd0, ADn, CSn, WRn, RDn}, 64'hf);
        check("rst_bus", {55'd0, ad_oe, ad_out}, 64'd0);
        check("rst_outs", {16'd0, anio, mes, dia, hora, min, seg}, 64'd0);
        check("rst_flags", {62'd0, valid, busy}, 64'd0);
        reset = 1'b0;

        en = 1'b1;
        bad = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (!(ADn && CSn && WRn && RDn) || ad_oe || busy || valid) bad++;
        end
        check("idle_without_init", 64'(bad), 64'd0);

        init_done = 1'b1;
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (!valid && cnt < 400);
        check("first_valid_latency", 64'(cnt), 64'(LAT_FIRST));
        check("first_sweep", {16'd0, anio, mes, dia, hora, min, seg}, 64'h151413121110);

        // Random new contents land while the third register is being addressed.
        cnt = 0; chg = 0;
        do begin
            @(posedge clk); #1; cnt++;
            if (!chg && ad_oe && ad_out == 8'h23) begin
                for (int i = 0; i < NR; i++) mem[i] = 8'($urandom_range(255));
                chg = 1;
            end
        end while (!valid && cnt < 400);
        check("poll_period", 64'(cnt), 64'(LAT_PERIOD));
        check("tear_hora", {56'd0, hora}, {56'd0, mem[2]});

        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (ad_oe && ad_out == 8'h23) begin ok = 1; break; end
        end
        check("reach_reg3", {63'd0, ok}, 64'd1);
        en = 1'b0;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (!busy) begin ok = 1; break; end
        end
        check("abort_to_idle", {63'd0, ok}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("abort_last_read", {56'd0, last_read}, 64'h23);
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (valid || busy) bad++;
        end
        check("abort_quiet", 64'(bad), 64'd0);

        for (int i = 0; i < NR; i++) mem[i] = 8'($urandom_range(255));
        en = 1'b1;
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (!valid && cnt < 400);
        check("restart_latency", 64'(cnt), 64'(LAT_FIRST));
        check("restart_anio", {56'd0, anio}, {56'd0, mem[5]});

        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!WRn) begin ok = 1; break; end
        end
        check("reach_a_wr", {63'd0, ok}, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_strobes", {60'd0, ADn, CSn, WRn, RDn}, 64'hf);
        check("midrst_bus", {55'd0, ad_oe, ad_out}, 64'd0);
        check("midrst_outs", {16'd0, anio, mes, dia, hora, min, seg}, 64'd0);
        check("midrst_flags", {62'd0, valid, busy}, 64'd0);
        reset = 1'b0;

        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (ad_oe && ad_out == 8'h22) begin ok = 1; break; end
        end
        check("reach_reg2", {63'd0, ok}, 64'd1);
        init_done = 1'b0;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (!busy) begin ok = 1; break; end
        end
        check("init_drop_idle", {63'd0, ok}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("init_drop_last_read", {56'd0, last_read}, 64'h22);
        repeat (50) @(posedge clk);
        #1;
        check("no_pending_sweeps", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
